// File: rtl/decoder_seq_nx2n.sv
// Registered N-to-2^N one-hot decoder with valid/ready select capture, an
// autonomous scan mode with programmable dwell, and selectable output polarity.
module decoder_seq_nx2n #(
  parameter int N          = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int DWELL_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [N-1:0]       sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(1<<N)-1:0]  dout,
  output logic [N-1:0]       idx,
  output logic               busy,
  output logic               wrap,
  output logic [1:0]         dbg_state
);

  // Handshake: a select transfers on a rising edge where sel_valid and
  // sel_ready are both 1; sel_ready is 1 only in DECODE with en=1, and the
  // producer must hold sel stable while sel_valid is high without a transfer.

  localparam int W = 1 << N;
  localparam logic [W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [N-1:0] IDX_MAX  = {N{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t             state_q, state_d, mode_state;
  logic [N-1:0]       idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]       dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;

  function automatic logic [W-1:0] line_on(input logic [N-1:0] i);
    logic [W-1:0] v;
    v = {{(W-1){1'b0}}, 1'b1} << i;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  always_comb begin
    case (mode)
      2'b01:   mode_state = ST_DECODE;
      2'b10:   mode_state = ST_SCAN;
      default: mode_state = ST_IDLE;
    endcase
  end

  assign sel_ready = en && (state_q == ST_DECODE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    if (en) begin
      state_d = mode_state;
      busy_d  = (mode_state == ST_SCAN);
      case (mode_state)
        ST_IDLE: begin
          dout_d = INACTIVE;
        end
        ST_DECODE: begin
          // Entry edges hold dout: blank from IDLE, current line from SCAN.
          if (sel_ready && sel_valid) begin
            idx_d  = sel;
            dout_d = line_on(sel);
          end
        end
        ST_SCAN: begin
          if (state_q != ST_SCAN) begin
            idx_d  = '0;
            cnt_d  = '0;
            dout_d = line_on('0);
          end else if (cnt_q >= dwell) begin
            idx_d  = idx_q + 1'b1;
            cnt_d  = '0;
            dout_d = line_on(idx_q + 1'b1);
            wrap_d = (idx_q == IDX_MAX);
          end else begin
            cnt_d  = cnt_q + 1'b1;
          end
        end
        default: begin
          dout_d = INACTIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= INACTIVE;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dout      = dout_q;
  assign idx       = idx_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q && en;
  assign dbg_state = state_q;

endmodule
